// File: rtl/sdram_init_refresh_ctrl_if.sv
// rtl/sdram_init_refresh_ctrl_if.sv - command bus and refresh handshake between the controller and its arbiter
interface sdram_init_refresh_ctrl_if;
  logic        delay100;
  logic        ref_ack;
  logic        sdr_cs_n;
  logic        sdr_ras_n;
  logic        sdr_cas_n;
  logic        sdr_we_n;
  logic [11:0] sdr_a;
  logic [1:0]  sdr_ba;
  logic        init_done;
  logic        ref_req;
  logic        ref_busy;
  logic        ref_overrun;

  modport master (
    input  delay100, ref_ack,
    output sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_a, sdr_ba,
    output init_done, ref_req, ref_busy, ref_overrun
  );

  modport slave (
    output delay100, ref_ack,
    input  sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_a, sdr_ba,
    input  init_done, ref_req, ref_busy, ref_overrun
  );
endinterface

// File: rtl/sdram_init_refresh_ctrl.sv
// rtl/sdram_init_refresh_ctrl.sv - SDRAM power-up init sequencer and periodic auto-refresh requester
module sdram_init_refresh_ctrl #(
  parameter int unsigned TRP          = 3,
  parameter int unsigned TRFC         = 7,
  parameter int unsigned TMRD         = 2,
  parameter logic [11:0] MODE_REG     = 12'h027,
  parameter int unsigned REF_INTERVAL = 780
) (
  input logic                       clk,
  input logic                       rst_n,
  sdram_init_refresh_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    WAIT_PWR, PRE, W_TRP, REF1, W_RFC1, REF2, W_RFC2, LMR, W_MRD, IDLE, RREF, W_RFC3
  } state_t;

  localparam logic [3:0]  CMD_NOP = 4'b0111;
  localparam logic [3:0]  CMD_PRE = 4'b0010;
  localparam logic [3:0]  CMD_REF = 4'b0001;
  localparam logic [3:0]  CMD_LMR = 4'b0000;
  localparam logic [3:0]  TRP_LD  = 4'(TRP - 1);
  localparam logic [3:0]  TRFC_LD = 4'(TRFC - 1);
  localparam logic [3:0]  TMRD_LD = 4'(TMRD - 1);
  localparam logic [15:0] REQ_AT  = 16'(REF_INTERVAL - 1);
  localparam logic [15:0] OVR_AT  = 16'(2 * REF_INTERVAL - 1);

  state_t      state, state_nx;
  logic [3:0]  wait_cnt, wait_cnt_nx, wait_dec;
  logic [15:0] ref_cnt;
  logic [3:0]  cmd_q, cmd_nx;
  logic [11:0] a_q, a_nx;
  logic [1:0]  ba_q, ba_nx;
  logic        busy_q, busy_nx;
  logic        done_q, req_q, ovr_q;
  logic        accept;

  // A state named after a command is the very cycle that command is on the pins.
  assign wait_dec = (wait_cnt == 4'd0) ? 4'd0 : wait_cnt - 4'd1;
  assign accept   = (state == IDLE) && bus.ref_ack && req_q;

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_dec;
    cmd_nx      = CMD_NOP;
    a_nx        = '0;
    ba_nx       = '0;
    case (state)
      WAIT_PWR: begin
        wait_cnt_nx = '0;
        if (bus.delay100) begin state_nx = PRE; wait_cnt_nx = TRP_LD; end
      end
      PRE:    state_nx = W_TRP;
      W_TRP:  if (wait_cnt == 4'd0) begin state_nx = REF1; wait_cnt_nx = TRFC_LD; end
      REF1:   state_nx = W_RFC1;
      W_RFC1: if (wait_cnt == 4'd0) begin state_nx = REF2; wait_cnt_nx = TRFC_LD; end
      REF2:   state_nx = W_RFC2;
      W_RFC2: if (wait_cnt == 4'd0) begin state_nx = LMR; wait_cnt_nx = TMRD_LD; end
      LMR:    state_nx = W_MRD;
      W_MRD:  if (wait_cnt == 4'd0) state_nx = IDLE;
      IDLE: begin
        wait_cnt_nx = '0;
        if (accept) begin state_nx = RREF; wait_cnt_nx = TRFC_LD; end
      end
      // Countdown is held here so W_RFC3 alone spans a full TRFC.
      RREF: begin state_nx = W_RFC3; wait_cnt_nx = wait_cnt; end
      W_RFC3: if (wait_cnt == 4'd0) state_nx = IDLE;
      default: begin state_nx = WAIT_PWR; wait_cnt_nx = '0; end
    endcase
    case (state_nx)
      PRE:              begin cmd_nx = CMD_PRE; a_nx = 12'h400; end
      REF1, REF2, RREF: cmd_nx = CMD_REF;
      LMR:              begin cmd_nx = CMD_LMR; a_nx = MODE_REG; end
      default:          cmd_nx = CMD_NOP;
    endcase
    busy_nx = state_nx inside {PRE, W_TRP, REF1, W_RFC1, REF2, W_RFC2, LMR, W_MRD, RREF, W_RFC3};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_PWR;
      wait_cnt <= '0;
      cmd_q    <= CMD_NOP;
      a_q      <= '0;
      ba_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
      ovr_q    <= 1'b0;
      ref_cnt  <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      cmd_q    <= cmd_nx;
      a_q      <= a_nx;
      ba_q     <= ba_nx;
      busy_q   <= busy_nx;
      if (state == W_MRD && state_nx == IDLE) done_q <= 1'b1;
      if (!done_q || accept) ref_cnt <= '0;
      else if (ref_cnt != 16'hFFFF) ref_cnt <= ref_cnt + 16'd1;
      if (accept) req_q <= 1'b0;
      else if (done_q && ref_cnt == REQ_AT) req_q <= 1'b1;
      if (req_q && ref_cnt == OVR_AT) ovr_q <= 1'b1;
    end
  end

  assign {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = cmd_q;
  assign bus.sdr_a       = a_q;
  assign bus.sdr_ba      = ba_q;
  assign bus.init_done   = done_q;
  assign bus.ref_req     = req_q;
  assign bus.ref_busy    = busy_q;
  assign bus.ref_overrun = ovr_q;
endmodule

// File: tb/tb_sdram_init_refresh_ctrl.sv
// tb/tb_sdram_init_refresh_ctrl.sv - randomized bench against a timeline model of init and refresh
module tb_sdram_init_refresh_ctrl;
  localparam int TRP  = 3;
  localparam int TRFC = 7;
  localparam int TMRD = 2;
  localparam int RI   = 780;
  localparam logic [11:0] MODE = 12'h027;
  localparam int BIG  = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sdram_init_refresh_ctrl_if bus();

  sdram_init_refresh_ctrl #(
    .TRP(TRP), .TRFC(TRFC), .TMRD(TMRD), .MODE_REG(MODE), .REF_INTERVAL(RI)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: the whole history is a few timestamps; outputs follow from them.
  int t0 = -1, done_at = BIG, ref_at = -1, zero_at = 0;
  bit req_m = 1'b0, ovr_m = 1'b0;

  function automatic logic [21:0] model_out(input int c);
    logic [3:0]  cmd;
    logic [11:0] a;
    logic        d, b;
    cmd = 4'b0111; a = '0; d = 1'b0; b = 1'b0;
    if (t0 >= 0) begin
      if (c == t0) begin cmd = 4'b0010; a = 12'h400; end
      else if (c == t0 + TRP || c == t0 + TRP + TRFC || c == ref_at) cmd = 4'b0001;
      else if (c == t0 + TRP + 2 * TRFC) begin cmd = 4'b0000; a = MODE; end
      d = (c >= done_at);
      b = (c >= t0 && c < done_at) || (ref_at >= 0 && c >= ref_at && c <= ref_at + TRFC);
    end
    return {cmd, a, 2'b00, d, req_m, b, ovr_m};
  endfunction

  int pre_q[$], ar_q[$], done_q[$], req_q[$], ovr_q[$], bstart_q[$], blen_q[$];
  int busy_cnt = 0, cmd_cnt = 0;
  logic [11:0] lmr_a_last = '0;

  function automatic int first_at(input int q[$], input int from);
    foreach (q[i]) if (q[i] >= from) return q[i];
    return -1;
  endfunction

  function automatic int run_len(input int s);
    foreach (bstart_q[i]) if (bstart_q[i] == s) return blen_q[i];
    return -1;
  endfunction

  logic [21:0] m_act, m_exp;
  logic [3:0]  m_cmd;
  int          m_c, m_cnt, m_bstart;
  logic        p_done = 0, p_req = 0, p_ovr = 0, p_busy = 0;
  bit          m_inref, m_idle;

  initial forever begin
    @(negedge clk);
    m_c   = cyc;
    m_cmd = {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n};
    m_act = {m_cmd, bus.sdr_a, bus.sdr_ba, bus.init_done, bus.ref_req, bus.ref_busy, bus.ref_overrun};
    if (!rst_n) begin
      t0 = -1; done_at = BIG; ref_at = -1; req_m = 0; ovr_m = 0;
      m_exp = {4'b0111, 12'h000, 2'b00, 4'b0000};
    end else begin
      m_exp = model_out(m_c);
    end
    check($sformatf("outputs@%0d", m_c), 32'(m_act), 32'(m_exp));

    if (rst_n) begin
      if (m_cmd == 4'b0010) pre_q.push_back(m_c);
      if (m_cmd == 4'b0001) ar_q.push_back(m_c);
      if (m_cmd == 4'b0000) lmr_a_last = bus.sdr_a;
      if (m_cmd != 4'b0111) cmd_cnt++;
      if (bus.init_done && !p_done) done_q.push_back(m_c);
      if (bus.ref_req && !p_req) req_q.push_back(m_c);
      if (bus.ref_overrun && !p_ovr) ovr_q.push_back(m_c);
      if (bus.ref_busy) busy_cnt++;
    end
    if (bus.ref_busy && !p_busy) m_bstart = m_c;
    if (!bus.ref_busy && p_busy) begin bstart_q.push_back(m_bstart); blen_q.push_back(m_c - m_bstart); end
    p_done = bus.init_done; p_req = bus.ref_req; p_ovr = bus.ref_overrun; p_busy = bus.ref_busy;

    // Advance the model with the inputs the next edge will sample.
    if (rst_n) begin
      m_inref = ref_at >= 0 && m_c >= ref_at && m_c <= ref_at + TRFC;
      m_idle  = t0 >= 0 && m_c >= done_at && !m_inref;
      if (t0 < 0) begin
        if (bus.delay100) begin
          t0 = m_c + 1;
          done_at = t0 + TRP + 2 * TRFC + TMRD;
          zero_at = done_at;
        end
      end else if (m_c >= done_at) begin
        m_cnt = m_c - zero_at;
        if (m_cnt > 65535) m_cnt = 65535;
        if (req_m && m_cnt == 2 * RI - 1) ovr_m = 1;
        if (m_idle && bus.ref_ack && req_m) begin
          ref_at = m_c + 1; zero_at = m_c + 1; req_m = 0;
        end else if (m_cnt == RI - 1) begin
          req_m = 1;
        end
      end
    end
  end

  int d_c, d2, b0, k0, t_h, a0, a1, a2;

  initial begin
    bus.delay100 = 1'b0;
    bus.ref_ack  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_cmd", {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n}, 4'b0111);

    // Power-up wait: nothing may happen, stray acks included.
    b0 = busy_cnt; k0 = cmd_cnt;
    repeat (200) begin @(posedge clk); #1 bus.ref_ack = ($urandom_range(0, 3) == 0); end
    check("pwr_busy_cycles", busy_cnt - b0, 0);
    check("pwr_cmds", cmd_cnt - k0, 0);
    check("pwr_done", bus.init_done, 1'b0);

    // Init sequence with ack noise.
    @(posedge clk); #1 d_c = cyc; bus.delay100 = 1'b1;
    repeat (40) begin @(posedge clk); #1 bus.ref_ack = $urandom_range(0, 1); end
    bus.ref_ack = 1'b0;
    check("pre_cycle",  first_at(pre_q, d_c), d_c + 1);
    check("ref1_cycle", first_at(ar_q, d_c), d_c + 4);
    check("ref2_cycle", first_at(ar_q, d_c + 5), d_c + 11);
    check("lmr_addr",   lmr_a_last, 12'h027);
    check("done_cycle", first_at(done_q, d_c), d_c + 20);
    check("init_busy_len", run_len(d_c + 1), 19);

    // No ack: request stays up and overrun follows.
    while (cyc < d_c + 20 + 2 * RI + 5) begin @(posedge clk); #1; end
    check("req_rise", first_at(req_q, d_c), d_c + 20 + RI);
    check("ovr_rise", first_at(ovr_q, d_c), d_c + 20 + 2 * RI);
    check("req_held", bus.ref_req, 1'b1);

    // Ack tied high: periodic refresh.
    t_h = cyc; bus.ref_ack = 1'b1;
    repeat (3 * (RI + 1) + 30) begin @(posedge clk); #1; end
    bus.ref_ack = 1'b0;
    a0 = first_at(ar_q, t_h);
    a1 = first_at(ar_q, a0 + 1);
    a2 = first_at(ar_q, a1 + 1);
    check("ack_latency", a0, t_h + 1);
    check("ref_period1", a1 - a0, RI + 1);
    check("ref_period2", a2 - a1, RI + 1);
    check("ref_busy_len0", run_len(a0), TRFC + 1);
    check("ref_busy_len1", run_len(a1), TRFC + 1);

    // Random acks and a wandering delay100.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      bus.ref_ack = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 99) == 0) bus.delay100 = ~bus.delay100;
    end
    bus.ref_ack = 1'b0;

    // Reset mid-init, then a clean restart.
    @(posedge clk); #1 rst_n = 1'b0; bus.delay100 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat ($urandom_range(2, 6)) @(posedge clk);
    #1 d_c = cyc; bus.delay100 = 1'b1;
    repeat (7) @(posedge clk);
    #2 check("mid_init_busy", bus.ref_busy, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("async_cmd", {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n}, 4'b0111);
    check("async_flags", {bus.init_done, bus.ref_req, bus.ref_busy, bus.ref_overrun}, 4'b0000);
    bus.delay100 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat ($urandom_range(3, 9)) @(posedge clk);
    #1 d2 = cyc; bus.delay100 = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("restart_pre",  first_at(pre_q, d2), d2 + 1);
    check("restart_done", first_at(done_q, d2), d2 + 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
